// File: rtl/pma_rx_pkg.sv
// Shared constants and types for the PMA receive deserializer.
package pma_rx_pkg;

    // K28.5 in both running disparities, as seen in the 10-bit window
    // with bit0 = first bit received.
    localparam logic [9:0] K28_5_RDN = 10'h17C;
    localparam logic [9:0] K28_5_RDP = 10'h283;

    // Width of the good/bad comma counters (limits are 1..15).
    localparam int CNT_W = 4;

    // Last phase of a 10-bit symbol.
    localparam logic [3:0] PH_LAST = 4'd9;

    typedef enum logic [1:0] {
        UNLOCKED  = 2'd0,
        CANDIDATE = 2'd1,
        LOCKED    = 2'd2
    } rx_state_t;

    // True when the window holds a K28.5 of either disparity.
    function automatic logic is_comma(input logic [9:0] w);
        return (w == K28_5_RDN) || (w == K28_5_RDP);
    endfunction

endpackage

// File: rtl/pma_rx_comma_det.sv
// Combinational comma detector: classifies a K28.5 in the window as
// landing on the current symbol boundary or off it.
module pma_rx_comma_det
    import pma_rx_pkg::*;
(
    input  logic [9:0] shreg,
    input  logic [3:0] ph,
    output logic       match,
    output logic       aligned,
    output logic       misaligned
);

    assign match      = is_comma(shreg);
    // A comma on the last phase is on the boundary, never a misalignment.
    assign aligned    = match && (ph == PH_LAST);
    assign misaligned = match && (ph != PH_LAST);

endmodule

// File: rtl/pma_rx_deserializer.sv
// Receive PMA deserializer: shifts the serial line LSB first into a 10-bit
// window, hunts for K28.5 to find the symbol boundary, and once locked
// strobes aligned symbols to the 8b/10b decoder.
//
// Output handshake: Data_Valid is a one-cycle push strobe with no ready/
// backpressure; Data_out is only meaningful on the Data_Valid cycle and
// holds its last strobed value otherwise. Comma_Det pulses on any boundary
// carrying a comma, whether or not Data_Valid is high.
module pma_rx_deserializer
    import pma_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int LOCK_COUNT = 3,
    parameter int LOSS_COUNT = 4
) (
    input  logic                  Bit_Rate_Clk,
    input  logic                  Rst,
    input  logic                  RX_In_P,
    input  logic                  RX_In_N,
    input  logic                  Align_En,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  Data_Valid,
    output logic                  Comma_Det,
    output logic                  Locked,
    output logic                  Diff_Err
);

    localparam logic [CNT_W-1:0] LOCK_N = LOCK_COUNT[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LOSS_N = LOSS_COUNT[CNT_W-1:0];

    logic [DATA_WIDTH-1:0] shreg;
    logic [3:0]            ph;
    logic [CNT_W-1:0]      good_cnt;
    logic [CNT_W-1:0]      bad_cnt;
    rx_state_t             state;

    logic match;
    logic aligned;
    logic misaligned;
    logic realign;
    logic boundary;

    pma_rx_comma_det u_comma_det (
        .shreg      (shreg),
        .ph         (ph),
        .match      (match),
        .aligned    (aligned),
        .misaligned (misaligned)
    );

    // Slipping the boundary onto a stray comma is only allowed while hunting.
    assign realign  = Align_En && misaligned && (state != LOCKED);
    assign boundary = (ph == PH_LAST) || realign;
    assign Locked   = (state == LOCKED);

    // Serial shift: newest bit enters at the top, shreg[0] is the oldest.
    always_ff @(posedge Bit_Rate_Clk) begin
        if (Rst) begin
            shreg <= '0;
        end else begin
            shreg <= {RX_In_P, shreg[DATA_WIDTH-1:1]};
        end
    end

    // Symbol phase counter, restarted on every boundary (natural or realign).
    always_ff @(posedge Bit_Rate_Clk) begin
        if (Rst) begin
            ph <= '0;
        end else if (boundary) begin
            ph <= '0;
        end else begin
            ph <= ph + 4'd1;
        end
    end

    // Alignment FSM with its good/bad comma counters.
    always_ff @(posedge Bit_Rate_Clk) begin
        if (Rst) begin
            state    <= UNLOCKED;
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            case (state)
                UNLOCKED: begin
                    if (Align_En && match) begin
                        good_cnt <= 4'd1;
                        if (LOCK_N == 4'd1) begin
                            state   <= LOCKED;
                            bad_cnt <= '0;
                        end else begin
                            state <= CANDIDATE;
                        end
                    end
                end
                CANDIDATE: begin
                    if (aligned) begin
                        good_cnt <= good_cnt + 4'd1;
                        if ((good_cnt + 4'd1) >= LOCK_N) begin
                            state   <= LOCKED;
                            bad_cnt <= '0;
                        end
                    end else if (misaligned && Align_En) begin
                        good_cnt <= 4'd1;
                    end
                end
                LOCKED: begin
                    if (aligned) begin
                        bad_cnt <= '0;
                    end else if (misaligned && Align_En) begin
                        if ((bad_cnt + 4'd1) >= LOSS_N) begin
                            state    <= UNLOCKED;
                            good_cnt <= '0;
                            bad_cnt  <= '0;
                        end else begin
                            bad_cnt <= bad_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state    <= UNLOCKED;
                    good_cnt <= '0;
                    bad_cnt  <= '0;
                end
            endcase
        end
    end

    // Symbol output registers, loaded one edge after the boundary cycle.
    always_ff @(posedge Bit_Rate_Clk) begin
        if (Rst) begin
            Data_out   <= '0;
            Data_Valid <= 1'b0;
            Comma_Det  <= 1'b0;
        end else begin
            Data_Valid <= boundary && (state == LOCKED);
            Comma_Det  <= boundary && match;
            if (boundary && (state == LOCKED)) begin
                Data_out <= shreg;
            end
        end
    end

    // Line integrity flag, independent of alignment.
    always_ff @(posedge Bit_Rate_Clk) begin
        if (Rst) begin
            Diff_Err <= 1'b0;
        end else begin
            Diff_Err <= (RX_In_P == RX_In_N);
        end
    end

endmodule

// File: tb/tb_pma_rx_deserializer.sv
// Bench for pma_rx_deserializer: expected symbols are queued as the line is
// driven and compared whenever Data_Valid strobes.
module tb_pma_rx_deserializer;

    logic       Bit_Rate_Clk = 1'b0;
    logic       Rst          = 1'b1;
    logic       RX_In_P      = 1'b0;
    logic       RX_In_N      = 1'b1;
    logic       Align_En     = 1'b1;
    logic [9:0] Data_out;
    logic       Data_Valid;
    logic       Comma_Det;
    logic       Locked;
    logic       Diff_Err;

    int pass_cnt       = 0;
    int total_cnt      = 0;
    int cyc            = 0;
    int last_valid_cyc = 0;
    int valid_gap      = 0;
    int valid_cnt      = 0;

    // {comma_det, data_out} per expected strobe
    logic [10:0] exp_q[$];

    localparam logic [9:0] C_RDN  = 10'h17C;
    localparam logic [9:0] C_RDP  = 10'h283;
    localparam logic [9:0] D_2AA  = 10'h2AA;
    localparam logic [9:0] D_155  = 10'h155;
    localparam logic [9:0] FILL   = 10'h0AA;  // low 9 bits used as filler
    localparam logic [9:0] W_SL1  = 10'h2F8;  // comma window slipped by one bit
    localparam logic [9:0] W_FILL = 10'h154;  // comma bit9 followed by filler

    typedef struct {
        logic [9:0] sym;
        logic       comma;
    } vec_t;

    vec_t vecs[6];

    // ---------------- clock / reset ----------------
    always #5 Bit_Rate_Clk = ~Bit_Rate_Clk;

    initial begin
        forever begin
            @(posedge Bit_Rate_Clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded, required finish before 500000");
        $fatal(1, "watchdog");
    end

    pma_rx_deserializer #(
        .DATA_WIDTH (10),
        .LOCK_COUNT (3),
        .LOSS_COUNT (4)
    ) dut (
        .Bit_Rate_Clk (Bit_Rate_Clk),
        .Rst          (Rst),
        .RX_In_P      (RX_In_P),
        .RX_In_N      (RX_In_N),
        .Align_En     (Align_En),
        .Data_out     (Data_out),
        .Data_Valid   (Data_Valid),
        .Comma_Det    (Comma_Det),
        .Locked       (Locked),
        .Diff_Err     (Diff_Err)
    );

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every strobe must match the head of the expected queue.
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge Bit_Rate_Clk);
            if (Data_Valid) begin
                valid_cnt++;
                valid_gap      = cyc - last_valid_cyc;
                last_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_valid: got strobe with Data_out 0x%0h, expected none (cycle %0d)",
                             Data_out, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("data_out", 32'(Data_out), 32'(e[9:0]));
                    check("comma_det", 32'(Comma_Det), 32'(e[10]));
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send_raw(input logic p, input logic n);
        RX_In_P = p;
        RX_In_N = n;
        @(posedge Bit_Rate_Clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        send_raw(b, ~b);
    endtask

    task automatic send_range(input logic [9:0] s, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_bit(s[i]);
    endtask

    task automatic send_sym(input logic [9:0] s);
        send_range(s, 0, 9);
    endtask

    task automatic push(input logic comma, input logic [9:0] s);
        exp_q.push_back({comma, s});
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        repeat (3) send_bit(1'b0);
        Rst = 1'b0;
    endtask

    task automatic flush_and_drain(input string name);
        send_bit(1'b0);
        send_bit(1'b0);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0] = '{sym: D_2AA, comma: 1'b0};
        vecs[1] = '{sym: D_155, comma: 1'b0};
        vecs[2] = '{sym: C_RDN, comma: 1'b1};
        vecs[3] = '{sym: C_RDP, comma: 1'b1};
        vecs[4] = '{sym: D_2AA, comma: 1'b0};
        vecs[5] = '{sym: C_RDN, comma: 1'b1};

        #1;
        // Reset then idle line
        do_reset();
        check("rst_locked", 32'(Locked), 32'd0);
        check("rst_valid", 32'(Data_Valid), 32'd0);
        check("rst_data_out", 32'(Data_out), 32'd0);
        check("rst_comma_det", 32'(Comma_Det), 32'd0);
        check("rst_diff_err", 32'(Diff_Err), 32'd0);
        repeat (30) send_bit(1'b0);
        repeat (30) send_bit(1'b1);
        check("idle_locked", 32'(Locked), 32'd0);
        check("idle_valid_cnt", 32'(valid_cnt), 32'd0);
        check("idle_data_out", 32'(Data_out), 32'd0);

        // Lock acquisition at a 3-bit offset, then table-driven symbols
        do_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        repeat (3) send_sym(C_RDN);
        check("lock_not_early", 32'(Locked), 32'd0);
        push(1'b1, C_RDN);
        send_bit(C_RDN[0]);
        check("lock_rise", 32'(Locked), 32'd1);
        send_range(C_RDN, 1, 9);
        for (int i = 0; i < 6; i++) begin
            push(vecs[i].comma, vecs[i].sym);
            send_sym(vecs[i].sym);
            check("vec_locked", 32'(Locked), 32'd1);
        end
        flush_and_drain("lock_drained");
        check("valid_gap", 32'(valid_gap), 32'd10);

        // Candidate realign: stray bits after two commas restart the count
        do_reset();
        send_sym(C_RDN);
        send_sym(C_RDN);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_sym(C_RDN);
        send_sym(C_RDN);
        check("slip_not_locked", 32'(Locked), 32'd0);
        send_sym(C_RDN);
        check("slip_not_early", 32'(Locked), 32'd0);
        push(1'b1, C_RDN);
        send_bit(C_RDN[0]);
        check("slip_lock_rise", 32'(Locked), 32'd1);
        send_range(C_RDN, 1, 9);
        flush_and_drain("slip_drained");

        // Loss of lock after four misaligned commas
        do_reset();
        repeat (3) send_sym(C_RDN);
        push(1'b1, C_RDN);
        send_sym(C_RDN);
        check("loss_pre_locked", 32'(Locked), 32'd1);
        send_bit(1'b0);
        for (int k = 0; k < 4; k++) begin
            push(1'b0, W_SL1);
            send_sym(C_RDN);
        end
        check("loss_hold_before", 32'(Locked), 32'd1);
        send_bit(C_RDN[0]);
        check("loss_fall", 32'(Locked), 32'd0);
        send_range(C_RDN, 1, 9);
        send_sym(C_RDN);
        send_sym(C_RDN);
        push(1'b1, C_RDN);
        send_sym(C_RDN);
        check("relock", 32'(Locked), 32'd1);
        // Aligned comma between misaligned runs clears the bad count
        send_bit(1'b0);
        for (int k = 0; k < 3; k++) begin
            push(1'b0, W_SL1);
            send_sym(C_RDN);
        end
        push(1'b0, W_FILL);
        send_range(FILL, 0, 8);
        push(1'b1, C_RDN);
        send_sym(C_RDN);
        send_bit(1'b0);
        for (int k = 0; k < 3; k++) begin
            push(1'b0, W_SL1);
            send_sym(C_RDN);
        end
        check("bad_cleared_locked", 32'(Locked), 32'd1);
        push(1'b0, W_FILL);
        send_range(FILL, 0, 8);
        flush_and_drain("loss_drained");
        check("bad_cleared_end", 32'(Locked), 32'd1);

        // Align_En = 0 keeps the hunt frozen
        do_reset();
        Align_En = 1'b0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        repeat (5) send_sym(C_RDN);
        send_bit(1'b0);
        check("align_off_unlocked", 32'(Locked), 32'd0);
        Align_En = 1'b1;
        repeat (3) send_sym(C_RDN);
        check("align_on_not_early", 32'(Locked), 32'd0);
        push(1'b1, C_RDN);
        send_sym(C_RDN);
        check("align_on_locked", 32'(Locked), 32'd1);
        flush_and_drain("align_drained");

        // Differential error pulse
        do_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        check("diff_err_idle", 32'(Diff_Err), 32'd0);
        send_raw(1'b1, 1'b1);
        check("diff_err_pulse", 32'(Diff_Err), 32'd1);
        send_bit(1'b1);
        check("diff_err_clear", 32'(Diff_Err), 32'd0);

        // Reset mid-symbol while locked forces a fresh hunt
        do_reset();
        repeat (3) send_sym(C_RDN);
        push(1'b1, C_RDN);
        send_sym(C_RDN);
        check("mid_pre_locked", 32'(Locked), 32'd1);
        send_range(D_2AA, 0, 3);
        Rst = 1'b1;
        send_bit(D_2AA[4]);
        Rst = 1'b0;
        check("mid_rst_locked", 32'(Locked), 32'd0);
        check("mid_rst_valid", 32'(Data_Valid), 32'd0);
        check("mid_rst_data_out", 32'(Data_out), 32'd0);
        send_range(D_2AA, 5, 9);
        send_sym(C_RDN);
        send_sym(C_RDN);
        check("rehunt_needed", 32'(Locked), 32'd0);
        send_sym(C_RDN);
        push(1'b1, C_RDN);
        send_sym(C_RDN);
        check("rehunt_locked", 32'(Locked), 32'd1);
        flush_and_drain("rehunt_drained");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pma_rx_deserializer.md
Name: pma_rx_deserializer

Overview:
- Receive-side PMA stage; consumes the differential serial line driven by the PMA TX serializer (LSB first, one bit per Bit_Rate_Clk).
- Shifts the line into a 10-bit window and hunts for K28.5 commas to find symbol boundaries.
- After LOCK_COUNT aligned commas, emits aligned 10-bit symbols with a one-cycle valid strobe to the downstream 8b/10b decoder.
- Single clock domain; no 10x-divided clock, so the symbol rate is expressed as a strobe.

Parameters:
- DATA_WIDTH, 10, symbol width; only 10 is supported.
- LOCK_COUNT, 3, consecutive aligned commas needed to enter LOCKED; range 1..15.
- LOSS_COUNT, 4, misaligned commas in LOCKED that force UNLOCKED; range 1..15.

Ports:
- Bit_Rate_Clk  in  1  serial bit clock.
- Rst  in  1  synchronous, active-high reset.
- RX_In_P  in  1  serial data, true leg; this leg is the data bit.
- RX_In_N  in  1  serial data, complement leg.
- Align_En  in  1  1 = realignment permitted; 0 = boundary frozen.
- Data_out  out  DATA_WIDTH  aligned symbol; bit0 = first bit received (code bit a).
- Data_Valid  out  1  one-cycle pulse per aligned symbol, only in LOCKED.
- Comma_Det  out  1  pulse: a comma was present at a symbol boundary (same cycle as Data_Valid, or on a realign).
- Locked  out  1  high in state LOCKED.
- Diff_Err  out  1  pulse: RX_In_P == RX_In_N was sampled.

Behaviour:
- Reset (Rst=1 at the clock edge): shreg=0, ph=0, good_cnt=0, bad_cnt=0, state=UNLOCKED, and all outputs 0. Reset mid-symbol discards the partial symbol.
- Shift register: every edge, shreg <= {RX_In_P, shreg[9:1]}. shreg[0] is therefore the oldest bit.
- Diff_Err is registered as (RX_In_P == RX_In_N). The data bit is still taken from RX_In_P.
- Comma match (combinational on shreg): shreg == 10'h17C (K28.5 RD-) or shreg == 10'h283 (RD+).
- Phase counter ph (0..9): boundary = (ph == 9) || realign. Next ph = boundary ? 0 : ph+1.
- realign = Align_En && match && ph != 9 && state != LOCKED.
- UNLOCKED:
  - On match with Align_En=1 (any ph): treat as a boundary, good_cnt <= 1, go to CANDIDATE.
  - If LOCK_COUNT == 1, go directly to LOCKED instead.
- CANDIDATE:
  - At a boundary with match: good_cnt+1; on reaching LOCK_COUNT, go to LOCKED and clear bad_cnt.
  - At a boundary without match: no change; data symbols between commas are legal.
  - Match off-boundary with Align_En=1: realign and set good_cnt <= 1.
- LOCKED:
  - Boundary is fixed; realign is never taken.
  - At a boundary with match: bad_cnt <= 0.
  - Match off-boundary: bad_cnt+1. On reaching LOSS_COUNT, go to UNLOCKED, with good_cnt=0 and bad_cnt=0.
  - If Align_En=0, bad_cnt holds and lock is never dropped.
- Align_En=0 in UNLOCKED or CANDIDATE: state, counters and ph continue free-running; no realign.
- Outputs, registered one edge after the boundary cycle:
  - Data_out <= shreg.
  - Data_Valid <= boundary && state==LOCKED. The evaluated state is the value before the edge.
  - Comma_Det <= boundary && match.
- Data_out holds its value between strobes.
- Latency: the last bit of a symbol enters shreg at edge k; Data_out/Data_Valid update at edge k+1.
- Locked is the registered state decode. The symbol that completes lock is not strobed; the first Data_Valid is the next boundary.
- Simultaneous events:
  - A match at ph==9 counts as aligned, never as misaligned.
  - Diff_Err is independent of all alignment logic.

Decomposition:
- Package pma_rx_pkg:
  - K28_5_RDN = 10'h17C and K28_5_RDP = 10'h283.
  - State enum {UNLOCKED, CANDIDATE, LOCKED}.
  - Counter width constant (4 bits).
- One sub-module, pma_rx_comma_det: combinational match on shreg.
  - Inputs: shreg, ph.
  - Outputs: match, aligned (match && ph==9), misaligned.
- The top level holds the shift register, ph, the FSM, the counters and the output registers.

Test Plan:
- Reset then idle: Rst high 3 cycles, line 0/1 -> all outputs 0, Locked=0, Data_Valid never pulses.
- Lock acquisition: arbitrary 3-bit offset, then 4x 17C, then data 0x2AA -> Locked rises one edge after the 3rd comma's last bit. The 4th comma strobes with Data_out=17C and Comma_Det=1. Next is Data_out=2AA, Comma_Det=0, with Data_Valid spaced exactly 10 cycles apart.
- Candidate realign: 2 aligned commas, then 5 stray bits, then 3 commas -> good_cnt restarts at 1. Lock occurs after the 3rd post-slip comma (LOCK_COUNT=3).
- Loss of lock: in LOCKED, insert 4 commas shifted by 1 bit -> Locked falls after the 4th. Once the stream is re-aligned, an aligned comma between misaligned ones resets bad_cnt so lock holds.
- Align_En=0: stream of commas at a fixed offset while UNLOCKED -> never leaves UNLOCKED. Setting Align_En=1 -> lock after 3 commas.
- Diff_Err and reset mid-operation: drive RX_In_N=RX_In_P for 1 bit -> single Diff_Err pulse. Assert Rst mid-symbol while LOCKED -> Locked=0 next edge and re-hunt is required.
